// File: rtl/uart_rx.sv
// UART receiver with an internal first-word-fall-through receive FIFO.
//
// Decodes frames of one start bit (0), DATA_WIDTH data bits sent LSB first, and one
// stop bit (1). Good bytes are pushed into the FIFO, and the host drains it with rx_re_i.
//
// Ports:
//   clk_i        single clock, all logic on posedge
//   rst_ni       synchronous active-low reset
//   baud_div_i   clk cycles per bit; values below 4 keep the receiver idle
//   rx_en_i      receiver enable; deasserting it discards any partial frame
//   rx_bit_i     asynchronous serial input, idle high
//   rx_re_i      pop the FIFO head; ignored when the FIFO is empty
//   dout_o       FIFO head, forced to 0 when the FIFO is empty
//   empty_o      FIFO empty
//   full_o       FIFO full
//   frame_err_o  1-cycle pulse: stop bit sampled low
//   overrun_o    1-cycle pulse: good frame dropped because the FIFO was full
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [15:0]           baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  rx_bit_i,
    input  logic                  rx_re_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  frame_err_o,
    output logic                  overrun_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastBit = IdxW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [15:0]           cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q;

    logic        fall, baud_ok, push, pop;
    logic [15:0] half_m1, bit_last;

    assign fall     = !rx_s_q && rx_prev_q;
    assign baud_ok  = baud_div_i >= 16'd4;
    assign half_m1  = (baud_div_i >> 1) - 16'd1;
    assign bit_last = baud_div_i - 16'd1;

    assign empty_o     = count_q == '0;
    assign full_o      = count_q == DepthCnt;
    assign pop         = rx_re_i && !empty_o;
    assign dout_o      = empty_o ? '0 : mem_q[rd_ptr_q];
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (!rx_en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (baud_ok && fall) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == half_m1) begin
                        cnt_d = '0;
                        idx_d = '0;
                        // A line that is high again by mid start bit was a glitch.
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StData: begin
                    if (cnt_q == bit_last) begin
                        cnt_d          = '0;
                        shreg_d[idx_q] = rx_s_q;
                        if (idx_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == bit_last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        if (!rx_s_q) begin
                            frame_err_d = 1'b1;
                        end else if (!full_o || rx_re_i) begin
                            // A same-cycle pop frees the slot this push lands in.
                            push = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_bit_i;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and count define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BAUD  = 104;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * BAUD;
    // Negedge index within a frame whose following posedge resolves the stop sample.
    localparam int STOP_IDX = 2 + BAUD / 2 + (DW + 1) * BAUD;

    logic          clk = 1'b0;
    logic          rst_n, rx_en, rx_bit, rx_re;
    logic [15:0]   baud_div;
    logic [DW-1:0] dout;
    logic          empty, full, frame_err, overrun;

    uart_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .baud_div_i  (baud_div),
        .rx_en_i     (rx_en),
        .rx_bit_i    (rx_bit),
        .rx_re_i     (rx_re),
        .dout_o      (dout),
        .empty_o     (empty),
        .full_o      (full),
        .frame_err_o (frame_err),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int full_drops = 0;
    logic [7:0] exp_q[$];

    int   fe_cycles = 0, fe_pulses = 0, ov_cycles = 0, ov_pulses = 0, both_cycles = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_err) begin
            fe_cycles <= fe_cycles + 1;
            if (!fe_prev) fe_pulses <= fe_pulses + 1;
        end
        if (overrun) begin
            ov_cycles <= ov_cycles + 1;
            if (!ov_prev) ov_pulses <= ov_pulses + 1;
        end
        if (frame_err && overrun) both_cycles <= both_cycles + 1;
        fe_prev <= frame_err;
        ov_prev <= overrun;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_bit = 1'b1;
        end
    endtask

    // Drives one frame, one line change per negedge. Optionally pops at the stop-sample
    // cycle, or aborts mid-frame by dropping rx_en (or rst_n) for three cycles.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int pop_idx,
                              input int abort_idx, input bit abort_rst);
        int slot;
        logic [31:0] exp;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            slot = i / BAUD;
            if (abort_idx >= 0 && i >= abort_idx) rx_bit = 1'b1;
            else if (slot == 0) rx_bit = 1'b0;
            else if (slot <= DW) rx_bit = data[slot-1];
            else rx_bit = stop;
            if (i == pop_idx) begin
                exp = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hdead;
                check_eq("pop_at_stop", {24'h0, dout}, exp);
                rx_re = 1'b1;
            end
            if (i == pop_idx + 1) rx_re = 1'b0;
            if (pop_idx >= 0 && i >= pop_idx - 2 && i <= pop_idx + 3 && !full) full_drops++;
            if (i == abort_idx) begin
                if (abort_rst) rst_n = 1'b0;
                else rx_en = 1'b0;
            end
            if (i == abort_idx + 3) begin
                rst_n = 1'b1;
                rx_en = 1'b1;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        int waited = 0;
        logic [31:0] exp;
        @(negedge clk);
        while (empty && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_avail"}, {31'h0, empty}, 32'h0);
        exp = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hdead;
        check_eq(tag, {24'h0, dout}, exp);
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_en = 1'b1; rx_bit = 1'b1; rx_re = 1'b0; baud_div = 16'(BAUD);
        repeat (5) @(negedge clk);
        check_eq("rst_dout", {24'h0, dout}, 32'h0);
        check_eq("rst_empty", {31'h0, empty}, 32'h1);
        check_eq("rst_full", {31'h0, full}, 32'h0);
        check_eq("rst_flags", {30'h0, frame_err, overrun}, 32'h0);
        rst_n = 1'b1;
        idle(20);

        // Back-to-back frames
        begin
            logic [7:0] seq [4] = '{8'h41, 8'h42, 8'h43, 8'h0A};
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(seq[k]);
                send_frame(seq[k], 1'b1, -1, -1, 1'b0);
            end
        end
        idle(BAUD);
        check_eq("t1_no_flags", 32'(fe_pulses + ov_pulses), 32'h0);
        for (int k = 0; k < 4; k++) pop_check("t1_pop");
        @(negedge clk);
        check_eq("t1_empty", {31'h0, empty}, 32'h1);
        check_eq("t1_dout_empty", {24'h0, dout}, 32'h0);

        // Short low glitch on an idle line
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rx_bit = 1'b0;
        end
        idle(2 * BAUD);
        check_eq("t2_empty", {31'h0, empty}, 32'h1);
        check_eq("t2_no_flags", 32'(fe_pulses + ov_pulses), 32'h0);

        // Framing error, then a good frame
        send_frame(8'h55, 1'b0, -1, -1, 1'b0);
        idle(2 * BAUD);
        check_eq("t3_fe_pulses", 32'(fe_pulses), 32'h1);
        check_eq("t3_fe_width", 32'(fe_cycles), 32'h1);
        check_eq("t3_empty", {31'h0, empty}, 32'h1);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
        idle(BAUD);
        pop_check("t3_pop");

        // Nine frames without popping
        for (int k = 0; k < 9; k++) begin
            if (k < 8) exp_q.push_back(8'(8'h10 + k));
            send_frame(8'(8'h10 + k), 1'b1, -1, -1, 1'b0);
            if (k == 7) begin
                idle(5);
                check_eq("t4_full_8", {31'h0, full}, 32'h1);
                check_eq("t4_no_ov_yet", 32'(ov_pulses), 32'h0);
            end
        end
        idle(BAUD);
        check_eq("t4_ov_pulses", 32'(ov_pulses), 32'h1);
        check_eq("t4_ov_width", 32'(ov_cycles), 32'h1);
        check_eq("t4_full", {31'h0, full}, 32'h1);
        for (int k = 0; k < 8; k++) pop_check("t4_pop");
        @(negedge clk);
        check_eq("t4_empty", {31'h0, empty}, 32'h1);

        // Full FIFO, pop coincides with the ninth frame's stop sample
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(8'(8'h20 + k));
            send_frame(8'(8'h20 + k), 1'b1, -1, -1, 1'b0);
        end
        check_eq("t5_full_before", {31'h0, full}, 32'h1);
        full_drops = 0;
        send_frame(8'h29, 1'b1, STOP_IDX, -1, 1'b0);
        exp_q.push_back(8'h29);
        idle(BAUD);
        check_eq("t5_full_after", {31'h0, full}, 32'h1);
        check_eq("t5_full_held", 32'(full_drops), 32'h0);
        check_eq("t5_no_overrun", 32'(ov_pulses), 32'h1);
        for (int k = 0; k < 8; k++) pop_check("t5_pop");
        @(negedge clk);
        check_eq("t5_empty", {31'h0, empty}, 32'h1);

        // Enable dropped mid-frame; FIFO contents kept
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        send_frame(8'h3C, 1'b1, -1, 4 * BAUD, 1'b0);
        idle(2 * BAUD);
        check_eq("t6_en_no_fe", 32'(fe_pulses), 32'h1);
        check_eq("t6_en_no_ov", 32'(ov_pulses), 32'h1);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1, -1, 1'b0);
        idle(BAUD);
        pop_check("t6_en_pop_kept");
        pop_check("t6_en_pop_c3");
        @(negedge clk);
        check_eq("t6_en_empty", {31'h0, empty}, 32'h1);

        // Reset mid-frame; FIFO flushed
        send_frame(8'h22, 1'b1, -1, -1, 1'b0);
        check_eq("t6_rst_pre", {31'h0, empty}, 32'h0);
        send_frame(8'h3C, 1'b1, -1, 4 * BAUD, 1'b1);
        check_eq("t6_rst_empty", {31'h0, empty}, 32'h1);
        check_eq("t6_rst_dout", {24'h0, dout}, 32'h0);
        idle(2 * BAUD);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1, -1, 1'b0);
        idle(BAUD);
        pop_check("t6_rst_pop");
        @(negedge clk);
        check_eq("t6_rst_final_empty", {31'h0, empty}, 32'h1);
        check_eq("flags_exclusive", 32'(both_cycles), 32'h0);
        check_eq("total_fe", 32'(fe_pulses), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
